// File: rtl/pll_clk_monitor_if.sv
// Signal bundle between housekeeping and the PLL clock monitor.
interface pll_clk_monitor_if #(
    parameter int CNT_WIDTH = 12
);
    logic                 ext_clk;
    logic                 enable;
    logic                 ext_clk_sel;
    logic [CNT_WIDTH-1:0] cnt_lo;
    logic [CNT_WIDTH-1:0] cnt_hi;
    logic                 clear_lost;
    logic                 pll_locked;
    logic                 ext_clk_sel_out;
    logic [CNT_WIDTH-1:0] period_count;
    logic                 count_valid;
    logic                 lock_lost;

    modport master (
        output ext_clk, enable, ext_clk_sel, cnt_lo, cnt_hi, clear_lost,
        input  pll_locked, ext_clk_sel_out, period_count, count_valid, lock_lost
    );

    modport slave (
        input  ext_clk, enable, ext_clk_sel, cnt_lo, cnt_hi, clear_lost,
        output pll_locked, ext_clk_sel_out, period_count, count_valid, lock_lost
    );
endinterface

// File: rtl/pll_clk_monitor.sv
// PLL frequency/lock monitor: counts pll_clk cycles per ext_clk period and
// only releases the clock mux onto the PLL after LOCK_COUNT in-range periods.
module pll_clk_monitor #(
    parameter int CNT_WIDTH  = 12,
    parameter int LOCK_COUNT = 4
) (
    input  logic             pll_clk,
    input  logic             resetb_async,
    pll_clk_monitor_if.slave mon
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ALIGN   = 2'd1,
        ST_MEASURE = 2'd2,
        ST_LOCKED  = 2'd3
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
    localparam logic [3:0]           LOCK_CNT = 4'(LOCK_COUNT);

    logic                 ext_s1_r, ext_s2_r, ext_s3_r;
    logic                 sel_s1_r, sel_s2_r;
    logic                 edge_s;
    logic                 in_range_s;
    state_t               state_r, state_next_s;
    logic [CNT_WIDTH-1:0] cnt_r, cnt_next_s;
    logic [CNT_WIDTH-1:0] period_r, period_next_s;
    logic [3:0]           good_r, good_next_s, good_inc_s;
    logic                 valid_r, valid_next_s;
    logic                 lost_r, lost_next_s, lost_set_s;
    logic                 locked_r;
    logic                 sel_out_r;

    assign edge_s     = ext_s2_r & ~ext_s3_r;
    assign in_range_s = (cnt_r >= mon.cnt_lo) && (cnt_r <= mon.cnt_hi);

    // Synchronisers for the asynchronous reference clock and clock select
    always_ff @(posedge pll_clk or negedge resetb_async) begin
        if (!resetb_async) begin
            ext_s1_r <= 1'b0;
            ext_s2_r <= 1'b0;
            ext_s3_r <= 1'b0;
            sel_s1_r <= 1'b0;
            sel_s2_r <= 1'b0;
        end else begin
            ext_s1_r <= mon.ext_clk;
            ext_s2_r <= ext_s1_r;
            ext_s3_r <= ext_s2_r;
            sel_s1_r <= mon.ext_clk_sel;
            sel_s2_r <= sel_s1_r;
        end
    end

    // Next-state, period capture and lock bookkeeping
    always_comb begin
        state_next_s  = state_r;
        cnt_next_s    = cnt_r;
        good_next_s   = good_r;
        period_next_s = period_r;
        valid_next_s  = 1'b0;
        lost_set_s    = 1'b0;
        if (good_r == LOCK_CNT) begin
            good_inc_s = good_r;
        end else begin
            good_inc_s = good_r + 4'd1;
        end

        if (!mon.enable) begin
            state_next_s = ST_IDLE;
            cnt_next_s   = CNT_ZERO;
            good_next_s  = 4'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_next_s = ST_ALIGN;
                    cnt_next_s   = CNT_ZERO;
                    good_next_s  = 4'd0;
                end
                ST_ALIGN: begin
                    if (edge_s) begin
                        cnt_next_s   = CNT_ONE;
                        state_next_s = ST_MEASURE;
                    end else begin
                        state_next_s = ST_ALIGN;
                    end
                end
                ST_MEASURE, ST_LOCKED: begin
                    if (edge_s) begin
                        period_next_s = cnt_r;
                        valid_next_s  = 1'b1;
                        cnt_next_s    = CNT_ONE;
                        if (in_range_s) begin
                            good_next_s = good_inc_s;
                            if (good_inc_s == LOCK_CNT) begin
                                state_next_s = ST_LOCKED;
                            end else begin
                                state_next_s = ST_MEASURE;
                            end
                        end else begin
                            good_next_s  = 4'd0;
                            lost_set_s   = (state_r == ST_LOCKED);
                            state_next_s = ST_MEASURE;
                        end
                    end else if (cnt_r == CNT_MAX) begin
                        // Reference stopped (or PLL far too fast): re-align from scratch
                        period_next_s = CNT_MAX;
                        valid_next_s  = 1'b1;
                        good_next_s   = 4'd0;
                        cnt_next_s    = CNT_ZERO;
                        lost_set_s    = (state_r == ST_LOCKED);
                        state_next_s  = ST_ALIGN;
                    end else begin
                        cnt_next_s = cnt_r + CNT_ONE;
                    end
                end
                default: begin
                    state_next_s = ST_IDLE;
                    cnt_next_s   = CNT_ZERO;
                    good_next_s  = 4'd0;
                end
            endcase
        end

        if (lost_set_s) begin
            lost_next_s = 1'b1;
        end else if (mon.clear_lost) begin
            lost_next_s = 1'b0;
        end else begin
            lost_next_s = lost_r;
        end
    end

    // State register and registered outputs
    always_ff @(posedge pll_clk or negedge resetb_async) begin
        if (!resetb_async) begin
            state_r   <= ST_IDLE;
            cnt_r     <= CNT_ZERO;
            good_r    <= 4'd0;
            period_r  <= CNT_ZERO;
            valid_r   <= 1'b0;
            lost_r    <= 1'b0;
            locked_r  <= 1'b0;
            sel_out_r <= 1'b1;
        end else begin
            state_r   <= state_next_s;
            cnt_r     <= cnt_next_s;
            good_r    <= good_next_s;
            period_r  <= period_next_s;
            valid_r   <= valid_next_s;
            lost_r    <= lost_next_s;
            locked_r  <= (state_next_s == ST_LOCKED);
            sel_out_r <= sel_s2_r | ~locked_r;
        end
    end

    assign mon.pll_locked      = locked_r;
    assign mon.ext_clk_sel_out = sel_out_r;
    assign mon.period_count    = period_r;
    assign mon.count_valid     = valid_r;
    assign mon.lock_lost       = lost_r;

endmodule
